gnn_node_sched: RTL and testbench
=================================

Name: gnn_node_sched

Overview:
- Time-multiplexed controller for the 4-node GNN. It replaces four parallel dnn_top instances with one shared dnn_top core.
- Latches one graph of node features and forms each node's neighbour-aggregated input vector.
- Issues the four nodes to the core in order 0..3 over a start/done handshake and stores the raw core outputs.
- Performs the output-side neighbour aggregation and presents all 8 results with a valid/ready handshake.
- Fixed adjacency: node0:{1,2}, node1:{0,3}, node2:{0,3}, node3:{1,2}.

Parameters:
- XW, 5, signed width of one node feature and core weight domain
- AW, 7, signed width of an aggregated core input (XW+2)
- RW, 20, signed width of a raw core output
- OW, 21, signed width of an aggregated graph output

Ports:
- clk  in  1  single clock; all flops on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  graph features valid
- in_ready  out  1  block can accept a graph (high only in IDLE)
- x_flat  in  16*XW  node n feature i at bits [(4n+i)*XW +: XW]
- core_x  out  4*AW  core inputs x0..x3, x_i at [i*AW +: AW]
- core_start  out  1  one-cycle pulse: core_x valid, start compute
- core_done  in  1  core out0/out1 valid (both core ready flags ANDed upstream)
- core_out0  in  RW  core raw output 0
- core_out1  in  RW  core raw output 1
- out_valid  out  1  aggregated results valid
- out_ready  in  1  downstream accepts results
- out_flat  out  8*OW  node n output k at [(2n+k)*OW +: OW]
- busy  out  1  high in every state except IDLE
- err  out  1  sticky: core_done seen outside WAIT; cleared only by reset
- core_clk_en  out  1  core clock enable (see Optional Feature)

Behaviour:
- Reset: state=IDLE, node_idx=0, in_ready=1, core_start=0, core_x=0, out_valid=0, out_flat=0, busy=0, err=0, raw store=0.
- Reset asserted mid-operation aborts immediately. A later core_done is ignored except that it sets err.
- FSM states: IDLE, ISSUE, WAIT, REDUCE, HOLD.
- IDLE, on in_valid&in_ready (cycle T):
  - latch x_flat;
  - register core_x = agg(node0);
  - go to ISSUE.
- Input aggregation: agg(n)_i = x[n][i] + x[nb1][i] + x[nb2][i], with sign-extension to AW. Exact; no overflow possible for XW=5.
- ISSUE (one cycle): core_start=1; go to WAIT. core_done in this cycle is ignored and sets err.
- WAIT: core_x held stable while waiting. On core_done:
  - store core_out0/out1 into raw[node_idx];
  - if node_idx<3: node_idx++, core_x=agg(node_idx+1), go to ISSUE;
  - else go to REDUCE.
- No timeout: WAIT holds indefinitely.
- REDUCE (one cycle): register out[n][k] = raw[n][k] + raw[nb1][k] + raw[nb2][k]. Each term is sign-extended to OW; the sum wraps modulo 2^OW. Go to HOLD.
- HOLD:
  - out_valid=1, out_flat stable;
  - on out_ready: out_valid=0, node_idx=0, go to IDLE;
  - in_valid is ignored while busy.
- out_flat keeps its last value after HOLD until the next REDUCE.
- Latency: with the core raising done L≥1 cycles after start:
  - starts at T+1+k(L+1), k=0..3;
  - out_valid first high at T+4L+6 (L=1 gives T+10).
- out_ready while out_valid=0 has no effect.
- Back-to-back graphs: the earliest next accept is the cycle after the HOLD handshake.

Optional Feature:
- Macro GNN_SCHED_CLK_GATE_EN.
- Defined: core_clk_en=1 only in ISSUE and WAIT, 0 in all other states including reset. It drives the core's clock gate.
- Undefined: core_clk_en tied to 1.
- All other behaviour is identical with or without the macro.

Test Plan:
- All 16 features=1; bench core gives out0=sum(core_x), out1=core_x0, L=1 → core_x=3,3,3,3 at every start; every node out0=36, out1=9; out_valid at T+10.
- Node n features all =n → core_x per node=3,4,5,6; raw out0=12,16,20,24 → out0 node0..3=48,52,56,60.
- Core returns out0=-524288 for every node → each out0 = -1572864 mod 2^21 = 524288 (wrap check).
- out_ready low 5 cycles in HOLD while in_valid=1 → out_valid and out_flat stable, in_ready=0, no new accept; out_ready=1 → IDLE next cycle.
- rst_n low during WAIT of node2, then core_done pulse after release → all outputs at reset values, state IDLE, err=1, no start issued.
- Macro defined, L=3 → core_clk_en high exactly from first ISSUE through last WAIT (16 cycles), low in IDLE, REDUCE and HOLD.

Source files
------------

// File: rtl/gnn_node_sched.sv
// Shares one dnn_top core across the four nodes of a fixed-adjacency GNN graph.
// Optional feature: define GNN_SCHED_CLK_GATE_EN to gate the core clock outside ISSUE/WAIT.
module gnn_node_sched #(
    parameter int unsigned XW = 5,
    parameter int unsigned AW = 7,
    parameter int unsigned RW = 20,
    parameter int unsigned OW = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16*XW-1:0] x_flat,
    output logic [4*AW-1:0]  core_x,
    output logic             core_start,
    input  logic             core_done,
    input  logic [RW-1:0]    core_out0,
    input  logic [RW-1:0]    core_out1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*OW-1:0]  out_flat,
    output logic             busy,
    output logic             err,
    output logic             core_clk_en
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StReduce,
        StHold
    } state_e;

    state_e           state;
    logic [1:0]       node_idx;
    logic [16*XW-1:0] x_lat;
    logic [RW-1:0]    raw [8];
    logic [4*AW-1:0]  agg_first;
    logic [4*AW-1:0]  agg_next;
    logic [8*OW-1:0]  red;

    function automatic logic [AW-1:0] sx_x(input logic [XW-1:0] v);
        return {{(AW - XW){v[XW-1]}}, v};
    endfunction

    function automatic logic [OW-1:0] sx_r(input logic [RW-1:0] v);
        return {{(OW - RW){v[RW-1]}}, v};
    endfunction

    // The neighbours of node n are exactly n^1 and n^2 for this adjacency.
    function automatic logic [4*AW-1:0] agg_node(input logic [16*XW-1:0] xs,
                                                 input logic [1:0]       n);
        logic [4*AW-1:0] r;
        logic [1:0]      nb1;
        logic [1:0]      nb2;
        nb1 = n ^ 2'd1;
        nb2 = n ^ 2'd2;
        r   = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*AW +: AW] = sx_x(xs[(4*int'(n) + i)*XW +: XW])
                          + sx_x(xs[(4*int'(nb1) + i)*XW +: XW])
                          + sx_x(xs[(4*int'(nb2) + i)*XW +: XW]);
        end
        return r;
    endfunction

    always_comb begin
        agg_first = agg_node(x_flat, 2'd0);
        agg_next  = agg_node(x_lat, node_idx + 2'd1);
    end

    always_comb begin
        red = '0;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 2; k++) begin
                red[(2*n + k)*OW +: OW] = sx_r(raw[3'(2*n + k)])
                                        + sx_r(raw[3'(2*(n ^ 1) + k)])
                                        + sx_r(raw[3'(2*(n ^ 2) + k)]);
            end
        end
    end

`ifdef GNN_SCHED_CLK_GATE_EN
    logic clk_en;
    assign core_clk_en = clk_en;
`else
    assign core_clk_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            node_idx   <= 2'd0;
            x_lat      <= '0;
            in_ready   <= 1'b1;
            core_start <= 1'b0;
            core_x     <= '0;
            out_valid  <= 1'b0;
            out_flat   <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                raw[i] <= '0;
            end
`ifdef GNN_SCHED_CLK_GATE_EN
            clk_en     <= 1'b0;
`endif
        end else begin
            // A done pulse can only be legitimate while a node is outstanding.
            if (core_done && (state != StWait)) begin
                err <= 1'b1;
            end
            core_start <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        x_lat      <= x_flat;
                        core_x     <= agg_first;
                        core_start <= 1'b1;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
`ifdef GNN_SCHED_CLK_GATE_EN
                        clk_en     <= 1'b1;
`endif
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    state <= StWait;
                end
                StWait: begin
                    if (core_done) begin
                        raw[{node_idx, 1'b0}] <= core_out0;
                        raw[{node_idx, 1'b1}] <= core_out1;
                        if (node_idx != 2'd3) begin
                            node_idx   <= node_idx + 2'd1;
                            core_x     <= agg_next;
                            core_start <= 1'b1;
                            state      <= StIssue;
                        end else begin
`ifdef GNN_SCHED_CLK_GATE_EN
                            clk_en <= 1'b0;
`endif
                            state  <= StReduce;
                        end
                    end
                end
                StReduce: begin
                    out_flat  <= red;
                    out_valid <= 1'b1;
                    state     <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        node_idx  <= 2'd0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_node_sched.sv
// Bench for gnn_node_sched: behavioural core model plus a graph-level reference model.
// Honours GNN_SCHED_CLK_GATE_EN when checking core_clk_en.
module tb_gnn_node_sched;

    localparam int XW = 5;
    localparam int AW = 7;
    localparam int RW = 20;
    localparam int OW = 21;

`ifdef GNN_SCHED_CLK_GATE_EN
    localparam bit Gated = 1'b1;
`else
    localparam bit Gated = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [16*XW-1:0] x_flat = '0;
    logic [4*AW-1:0]  core_x;
    logic             core_start;
    logic             core_done = 1'b0;
    logic [RW-1:0]    core_out0 = '0;
    logic [RW-1:0]    core_out1 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [8*OW-1:0]  out_flat;
    logic             busy;
    logic             err;
    logic             core_clk_en;

    gnn_node_sched #(.XW(XW), .AW(AW), .RW(RW), .OW(OW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x_flat      (x_flat),
        .core_x      (core_x),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_out0   (core_out0),
        .core_out1   (core_out1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_flat    (out_flat),
        .busy        (busy),
        .err         (err),
        .core_clk_en (core_clk_en)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Core model controls and observations.
    int              lat = 1;
    int              mode = 0;
    int              cnt = 0;
    int              node_ctr = 0;
    int              cur_node = 0;
    int              start_cnt = 0;
    logic            inj = 1'b0;
    logic [4*AW-1:0] cap_x [4];
    logic [RW-1:0]   rec0 [4];
    logic [RW-1:0]   rec1 [4];
    int              adj [4][2] = '{'{1, 2}, '{0, 3}, '{0, 3}, '{1, 2}};

    task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16*XW-1:0] rand_x();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[16*XW-1:0];
    endfunction

    function automatic int feat(input logic [16*XW-1:0] x, input int n, input int i);
        logic signed [XW-1:0] t;
        t = x[(4*n + i)*XW +: XW];
        return int'(t);
    endfunction

    function automatic logic [4*AW-1:0] ref_agg(input logic [16*XW-1:0] x, input int n);
        logic [4*AW-1:0] r;
        int              s;
        for (int i = 0; i < 4; i++) begin
            s = feat(x, n, i) + feat(x, adj[n][0], i) + feat(x, adj[n][1], i);
            r[i*AW +: AW] = s[AW-1:0];
        end
        return r;
    endfunction

    function automatic int rawv(input int m, input int k);
        logic signed [RW-1:0] t;
        t = (k == 0) ? rec0[m] : rec1[m];
        return int'(t);
    endfunction

    function automatic logic [8*OW-1:0] ref_out();
        logic [8*OW-1:0] r;
        int              s;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 2; k++) begin
                s = rawv(n, k) + rawv(adj[n][0], k) + rawv(adj[n][1], k);
                r[(2*n + k)*OW +: OW] = s[OW-1:0];
            end
        end
        return r;
    endfunction

    // Core model: done pulses lat cycles after each start; outputs chosen by mode.
    initial begin
        int                   s;
        logic                 dn;
        logic signed [AW-1:0] t;
        logic [31:0]          r;
        logic [RW-1:0]        o0;
        logic [RW-1:0]        o1;
        forever begin
            @(posedge clk);
            dn = inj;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (core_start) begin
                    cap_x[node_ctr & 3] = core_x;
                    cur_node = node_ctr & 3;
                    node_ctr++;
                    start_cnt++;
                    cnt = lat;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        dn = 1'b1;
                        s = 0;
                        for (int i = 0; i < 4; i++) begin
                            t = core_x[i*AW +: AW];
                            s += int'(t);
                        end
                        t = core_x[AW-1:0];
                        s = (mode == 1) ? -524288 : s;
                        o0 = s[RW-1:0];
                        s = int'(t);
                        o1 = s[RW-1:0];
                        if (mode == 2) begin
                            r  = $urandom();
                            o0 = r[RW-1:0];
                            r  = $urandom();
                            o1 = r[RW-1:0];
                        end
                        rec0[cur_node] = o0;
                        rec1[cur_node] = o1;
                        core_out0 <= o0;
                        core_out1 <= o1;
                    end
                end
            end
            core_done <= dn;
        end
    end

    // Applies one graph and runs it up to HOLD; leaves out_ready low.
    task automatic run_graph(input logic [16*XW-1:0] x, input int l, input int md,
                             input string tag);
        int n;
        int en_cnt;
        int s0;
        lat      = l;
        mode     = md;
        node_ctr = 0;
        s0       = start_cnt;
        @(negedge clk);
        x_flat   = x;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 168'(in_ready), 168'(1));
        n      = 0;
        en_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_valid = 1'b0;
                x_flat   = rand_x();
            end
            if (core_clk_en) en_cnt++;
        end while (!out_valid && n < 300);
        chk({tag, "_latency"}, 168'(n), 168'(4*l + 6));
        chk({tag, "_starts"}, 168'(start_cnt - s0), 168'(4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_core_x%0d", tag, k), 168'(cap_x[k]), 168'(ref_agg(x, k)));
        end
        chk({tag, "_out_flat"}, 168'(out_flat), 168'(ref_out()));
        chk({tag, "_busy"}, 168'(busy), 168'(1));
        chk({tag, "_hold_in_ready"}, 168'(in_ready), 168'(0));
        chk({tag, "_clk_en_cycles"}, 168'(en_cnt), 168'(Gated ? 4*(l + 1) : n));
        chk({tag, "_clk_en_hold"}, 168'(core_clk_en), 168'(!Gated));
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_after"}, 168'(out_valid), 168'(0));
        chk({tag, "_ir_after"}, 168'(in_ready), 168'(1));
        chk({tag, "_busy_after"}, 168'(busy), 168'(0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 168'(in_ready), 168'(1));
        chk({tag, "_busy"}, 168'(busy), 168'(0));
        chk({tag, "_core_start"}, 168'(core_start), 168'(0));
        chk({tag, "_core_x"}, 168'(core_x), 168'(0));
        chk({tag, "_out_valid"}, 168'(out_valid), 168'(0));
        chk({tag, "_out_flat"}, 168'(out_flat), 168'(0));
    endtask

    initial begin
        logic [16*XW-1:0] x;
        logic [8*OW-1:0]  hold_exp;
        int               s0;
        int               k;

        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        chk("rst_err", 168'(err), 168'(0));
        chk("rst_clk_en", 168'(core_clk_en), 168'(!Gated));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 168'(in_ready), 168'(1));

        // All features one: every aggregated input is 3.
        for (int f = 0; f < 16; f++) x[f*XW +: XW] = 5'd1;
        run_graph(x, 1, 0, "ones");
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("ones_o0_%0d", n), 168'(out_flat[(2*n)*OW +: OW]), 168'(36));
            chk($sformatf("ones_o1_%0d", n), 168'(out_flat[(2*n + 1)*OW +: OW]), 168'(9));
        end
        handshake("ones");

        // Node n features all equal n.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) x[(4*n + i)*XW +: XW] = XW'(n);
        end
        run_graph(x, 3, 0, "ramp");
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("ramp_o0_%0d", n), 168'(out_flat[(2*n)*OW +: OW]), 168'(48 + 4*n));
        end
        handshake("ramp");

        // Most negative raw output on every node: the three-way sum wraps.
        run_graph(rand_x(), 2, 1, "wrap");
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("wrap_o0_%0d", n), 168'(out_flat[(2*n)*OW +: OW]), 168'(524288));
        end
        handshake("wrap");

        // Stall in HOLD with a competing graph offered.
        run_graph(rand_x(), 2, 2, "stall");
        hold_exp = ref_out();
        s0 = start_cnt;
        x_flat   = rand_x();
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall_ov_%0d", c), 168'(out_valid), 168'(1));
            chk($sformatf("stall_of_%0d", c), 168'(out_flat), 168'(hold_exp));
            chk($sformatf("stall_ir_%0d", c), 168'(in_ready), 168'(0));
        end
        chk("stall_no_start", 168'(start_cnt - s0), 168'(0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("stall_ov_after", 168'(out_valid), 168'(0));
        chk("stall_ir_after", 168'(in_ready), 168'(1));
        chk("stall_of_kept", 168'(out_flat), 168'(hold_exp));

        // Random graphs with random core latency.
        for (int g = 0; g < 3; g++) begin
            run_graph(rand_x(), int'($urandom_range(4, 1)), 2, $sformatf("rnd%0d", g));
            handshake($sformatf("rnd%0d", g));
        end

        // Abort with reset while node 2 is outstanding, then a stray done.
        lat      = 3;
        mode     = 2;
        node_ctr = 0;
        @(negedge clk);
        x_flat   = rand_x();
        in_valid = 1'b1;
        k = 0;
        while (node_ctr < 3 && k < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            k++;
        end
        chk("abort_reached_node2", 168'(node_ctr), 168'(3));
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("abort_in_rst");
        chk("abort_in_rst_err", 168'(err), 168'(0));
        rst_n = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("abort_after");
        chk("abort_err", 168'(err), 168'(1));
        chk("abort_no_start", 168'(start_cnt - s0), 168'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
